// File: rtl/word_reduce_seq.sv
// Sequential bitwise reduction (AND/OR/XOR/NAND) of a W-bit word, C bits per cycle,
// with optional early exit once the result can no longer change.
module word_reduce_seq #(
  parameter int unsigned W     = 32,
  parameter int unsigned C     = 8,
  parameter int unsigned EARLY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         result,
  output logic         busy
);

  localparam int unsigned N    = W / C;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  localparam logic [1:0] ModeAnd  = 2'b00;
  localparam logic [1:0] ModeOr   = 2'b01;
  localparam logic [1:0] ModeXor  = 2'b10;
  localparam logic [1:0] ModeNand = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic [1:0]      mode_q, mode_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            acc_q, acc_d;

  logic [C-1:0]    chunk;
  logic            acc_upd;
  logic            early_hit;

  always_comb begin
    chunk   = data_q[idx_q*C +: C];
    acc_upd = acc_q;
    unique case (mode_q)
      ModeAnd, ModeNand: acc_upd = acc_q & (&chunk);
      ModeOr:            acc_upd = acc_q | (|chunk);
      ModeXor:           acc_upd = acc_q ^ (^chunk);
    endcase
    // AND/NAND saturate at 0, OR saturates at 1; XOR never saturates.
    early_hit = (EARLY != 0) && (mode_q != ModeXor) &&
                ((mode_q == ModeOr) ? acc_upd : !acc_upd);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = mode;
          idx_d   = '0;
          acc_d   = (mode == ModeOr || mode == ModeXor) ? 1'b0 : 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_upd;
        if (idx_q == LastIdx || early_hit) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      mode_q  <= ModeAnd;
      idx_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    result    = (state_q == StDone) ? (acc_q ^ (mode_q == ModeNand)) : 1'b0;
  end

endmodule

// File: tb/tb_word_reduce_seq.sv
// Directed bench for word_reduce_seq: 32/8 with and without early exit, plus a W=C=8 instance.
module tb_word_reduce_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  mode;
  logic        out_ready;

  logic in_ready_e, out_valid_e, result_e, busy_e;
  logic in_ready_n, out_valid_n, result_n, busy_n;
  logic in_ready_8, out_valid_8, result_8, busy_8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  word_reduce_seq #(.W(32), .C(8), .EARLY(1)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e), .in_data(in_data),
    .mode(mode), .out_valid(out_valid_e), .out_ready(out_ready), .result(result_e),
    .busy(busy_e)
  );

  word_reduce_seq #(.W(32), .C(8), .EARLY(0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
    .mode(mode), .out_valid(out_valid_n), .out_ready(out_ready), .result(result_n),
    .busy(busy_n)
  );

  word_reduce_seq #(.W(8), .C(8), .EARLY(1)) dut_8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_8), .in_data(in_data[7:0]),
    .mode(mode), .out_valid(out_valid_8), .out_ready(out_ready), .result(result_8),
    .busy(busy_8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word, hold out_ready low, measure latency/result on both 32-bit instances.
  task automatic xfer(input string tag, input logic [31:0] data, input logic [1:0] md,
                      input int lat_e, input int lat_n, input logic res);
    int   obs_le = 0;
    int   obs_ln = 0;
    logic obs_re = 1'b0;
    logic obs_rn = 1'b0;
    in_valid  = 1'b1;
    in_data   = data;
    mode      = md;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = ~data;
    chk({tag, " busy"}, {31'd0, busy_e}, 32'd1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (out_valid_e && obs_le == 0) begin obs_le = c; obs_re = result_e; end
      if (out_valid_n && obs_ln == 0) begin obs_ln = c; obs_rn = result_n; end
      if (!out_valid_e) chk({tag, " res0_e"}, {31'd0, result_e}, 32'd0);
    end
    chk({tag, " lat_e"}, obs_le, lat_e);
    chk({tag, " lat_n"}, obs_ln, lat_n);
    chk({tag, " res_e"}, {31'd0, obs_re}, {31'd0, res});
    chk({tag, " res_n"}, {31'd0, obs_rn}, {31'd0, res});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " rdy"}, {30'd0, in_ready_e, out_valid_e}, 32'b10);
    chk({tag, " idle_res"}, {31'd0, result_e}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    mode      = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("reset", {28'd0, in_ready_e, out_valid_e, busy_e, result_e}, 32'b1000);

    // Idle ignores data when in_valid is low.
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h1234_5678 * (i + 1);
      mode    = i[1:0];
      tick();
      chk("idle_hold", {30'd0, in_ready_e, busy_e}, 32'b10);
    end

    xfer("and_ff",   32'hFFFF_FFFF, 2'b00, 4, 4, 1'b1);
    xfer("and_mid0", 32'hFFFF_00FF, 2'b00, 2, 4, 1'b0);
    xfer("and_top0", 32'h00FF_FFFF, 2'b00, 4, 4, 1'b0);
    xfer("xor_7",    32'h0000_0007, 2'b10, 4, 4, 1'b1);
    xfer("xor_3",    32'h0300_0000, 2'b10, 4, 4, 1'b0);
    xfer("nand_ff",  32'hFFFF_FFFF, 2'b11, 4, 4, 1'b0);
    xfer("nand_e",   32'hFFFF_00FF, 2'b11, 2, 4, 1'b1);
    xfer("or_0",     32'h0000_0000, 2'b01, 4, 4, 1'b0);
    xfer("or_msb",   32'h8000_0000, 2'b01, 4, 4, 1'b1);
    xfer("or_c1",    32'h0000_0100, 2'b01, 2, 4, 1'b1);
    xfer("and_c0",   32'hFFFF_FF7F, 2'b00, 1, 4, 1'b0);

    // Stall in DONE while new data is offered.
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; mode = 2'b00; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_done", {30'd0, out_valid_e, result_e}, 32'b11);
    in_valid = 1'b1; in_data = 32'h0000_0000; mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {29'd0, out_valid_e, result_e, in_ready_e}, 32'b110);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_release", {29'd0, out_valid_e, in_ready_e, busy_e}, 32'b010);
    tick();
    in_valid = 1'b0;
    chk("stall_accept", {30'd0, in_ready_e, busy_e}, 32'b01);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_new", {30'd0, out_valid_e, result_e}, 32'b10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the second RUN cycle discards the word.
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; mode = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_run", {28'd0, in_ready_e, out_valid_e, busy_e, result_e}, 32'b1000);
    chk("rst_run_n", {28'd0, in_ready_n, out_valid_n, busy_n, result_n}, 32'b1000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale", {29'd0, out_valid_e, out_valid_n, result_e}, 32'd0);
    end

    // Reset while in DONE with out_ready also high: reset wins.
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; mode = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    chk("or_early_done", {30'd0, out_valid_e, result_e}, 32'b11);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("rst_done", {28'd0, in_ready_e, out_valid_e, busy_e, result_e}, 32'b1000);

    // W=C=8: single-cycle RUN, back-to-back words.
    in_valid = 1'b1; in_data = 32'h0000_00FF; mode = 2'b00; out_ready = 1'b1;
    tick();
    in_data = 32'h0000_00FE;
    chk("w8_acc1", {30'd0, in_ready_8, busy_8}, 32'b01);
    tick();
    chk("w8_res1", {30'd0, out_valid_8, result_8}, 32'b11);
    tick();
    chk("w8_idle", {30'd0, in_ready_8, out_valid_8}, 32'b10);
    tick();
    in_valid = 1'b0;
    chk("w8_acc2", {30'd0, in_ready_8, busy_8}, 32'b01);
    tick();
    chk("w8_res2", {30'd0, out_valid_8, result_8}, 32'b10);
    tick();
    chk("w8_end", {30'd0, in_ready_8, out_valid_8}, 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
